// File: rtl/score_ctrl.sv
// Game-phase controller for the on-screen score counter: sequences IDLE/PLAY/DRAIN/OVER,
// turns multi-point events into a one-per-clock increase pulse train and tracks the best score.
module score_ctrl #(
    parameter int HOLD_FRAMES = 180,
    parameter int PEND_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        game_over,
    input  logic        frame_tick,
    input  logic        point_evt,
    input  logic [1:0]  point_val,
    output logic        module_en,
    output logic        increase,
    output logic [1:0]  game_state,
    output logic [11:0] score_bcd,
    output logic [11:0] best_bcd,
    output logic        new_record
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_DRAIN = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam int              HOLD_W     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [4:0]      PEND_LIMIT = 5'(PEND_MAX);

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_pending;
    logic [11:0]         r_score;
    logic [11:0]         r_best;
    logic                r_newRecord;
    logic [HOLD_W-1:0]   r_hold;

    logic                w_increase;
    logic                w_accept;
    logic [1:0]          w_addVal;
    logic [4:0]          w_pendSum;
    logic [3:0]          w_pendNext;
    logic                w_holdDone;
    logic                w_drainDone;

    function automatic logic [11:0] bcdInc(input logic [11:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start)                 w_nextState = S_PLAY;
            S_PLAY:  if (game_over)             w_nextState = S_DRAIN;
            S_DRAIN: if (r_pending == 4'd0)     w_nextState = S_OVER;
            S_OVER:  if (start || w_holdDone)   w_nextState = S_IDLE;
            default:                            w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        module_en  = (r_state != S_IDLE);
        w_increase = ((r_state == S_PLAY) || (r_state == S_DRAIN)) && (r_pending != 4'd0);
        game_state = r_state;
    end

    // Accepted points and the pulse being emitted this cycle are netted before saturating,
    // so an add that lands on a full queue still loses only the true overflow.
    assign w_accept    = (r_state == S_PLAY) && point_evt && (point_val != 2'd0);
    assign w_addVal    = w_accept ? point_val : 2'd0;
    assign w_pendSum   = {1'b0, r_pending} + {3'b000, w_addVal} - {4'b0000, w_increase};
    assign w_pendNext  = (w_pendSum > PEND_LIMIT) ? PEND_LIMIT[3:0] : w_pendSum[3:0];
    assign w_holdDone  = frame_tick && (r_hold == HOLD_LAST);
    assign w_drainDone = (r_state == S_DRAIN) && (r_pending == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending   <= 4'd0;
            r_score     <= 12'h000;
            r_best      <= 12'h000;
            r_newRecord <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_pending <= w_pendNext;

            if (r_state == S_IDLE) begin
                r_score <= 12'h000;
            end else if (w_increase) begin
                r_score <= bcdInc(r_score);
            end

            // Packed BCD digits compare correctly as a plain unsigned number (hundreds dominate).
            if ((r_state == S_IDLE) && start) begin
                r_newRecord <= 1'b0;
            end else if (w_drainDone) begin
                if (r_score > r_best) begin
                    r_best      <= r_score;
                    r_newRecord <= 1'b1;
                end else begin
                    r_newRecord <= 1'b0;
                end
            end

            if ((r_state != S_OVER) || start || w_holdDone) begin
                r_hold <= '0;
            end else if (frame_tick) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign increase   = w_increase;
    assign score_bcd  = r_score;
    assign best_bcd   = r_best;
    assign new_record = r_newRecord;

endmodule
